muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the core's execute path. It sits between the register file's read ports and its write port. It captures rs1/rs2 read data and a destination address on a start pulse, computes over multiple cycles, then drives one write-back beat toward the register file's write port. The pipeline stalls on `busy_o`.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_iter_core.sv | 55 +++++
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
// Op encodings follow funct3; signedness helpers drive operand magnitude conversion.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_signed_a(muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one bit per step.
// Multiply leaves the 64-bit product in acc; divide leaves {remainder, quotient}.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] init_acc_i,
    input  logic [XLEN-1:0]   init_opnd_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [4:0]        cnt_o
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [4:0]        cnt;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;

    // opnd holds the multiplicand for multiply and the divisor for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_ge   = acc[63:31] >= {1'b0, opnd};
        div_diff = acc[62:31] - opnd;
        if (is_div_i) begin
            acc_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else if (load_i) begin
            acc  <= init_acc_i;
            opnd <= init_opnd_i;
            cnt  <= '0;
        end else if (step_i) begin
            acc  <= acc_next;
            cnt  <= cnt + 5'd1;
        end
    end

    assign acc_o = acc;
    assign cnt_o = cnt;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with FSM, sign handling and special cases.
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 signed multiplier for all multiplies.
module muldiv_unit #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            wr_en_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] wr_data_o
);
    import muldiv_pkg::*;

    muldiv_state_e state, state_next;
    muldiv_op_e    op_in, op_q;
    logic          sa, sb, is_div_in, div_zero, div_ovf, fast_mul, special, neg_in;
    logic          neg_q, raw_q, load, step;
    logic [4:0]    rd_q, cnt;
    logic [31:0]   a_mag, b_mag, res_q, result_c, div_word, div_fix;
    logic [63:0]   init_acc, acc, prod_fix;
    logic [31:0]   init_opnd;

    assign op_in     = muldiv_op_e'(funct3_i);
    assign sa        = is_signed_a(op_in) & rs1_data_i[31];
    assign sb        = is_signed_b(op_in) & rs2_data_i[31];
    assign a_mag     = sa ? (32'd0 - rs1_data_i) : rs1_data_i;
    assign b_mag     = sb ? (32'd0 - rs2_data_i) : rs2_data_i;
    assign is_div_in = funct3_i[2];
    assign div_zero  = is_div_in && (rs2_data_i == 32'd0);
    assign div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
    assign neg_in    = (op_in == OP_REM) ? sa : (sa ^ sb);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] fast_prod;
    assign fast_prod = $signed({sa, rs1_data_i}) * $signed({sb, rs2_data_i});
    assign fast_mul  = !is_div_in;
`else
    assign fast_mul  = 1'b0;
`endif
    assign special   = div_zero || div_ovf || fast_mul;

    // Special cases preload the final (already signed) value so DONE needs no extra logic.
    always_comb begin
        init_opnd = is_div_in ? b_mag : a_mag;
        init_acc  = {32'd0, is_div_in ? a_mag : b_mag};
`ifdef MULDIV_FAST_MUL_EN
        if (fast_mul) init_acc = fast_prod;
`endif
        if (div_zero) begin
            init_acc = {rs1_data_i, 32'hFFFF_FFFF};
        end else if (div_ovf) begin
            init_acc = {32'd0, 32'h8000_0000};
        end
    end

    muldiv_iter_core u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (load),
        .step_i      (step),
        .is_div_i    (op_q[2]),
        .init_acc_i  (init_acc),
        .init_opnd_i (init_opnd),
        .acc_o       (acc),
        .cnt_o       (cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_i && !kill_i) state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (kill_i)            state_next = ST_IDLE;
                else if (cnt == 5'd31) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state != ST_IDLE);
        done_o  = (state == ST_DONE);
        wr_en_o = done_o && (rd_q != 5'd0);
        load    = (state == ST_IDLE) && start_i && !kill_i;
        step    = (state == ST_CALC) && !kill_i;
    end

    always_comb begin
        prod_fix = (neg_q && !raw_q) ? (64'd0 - acc) : acc;
        div_word = op_q[1] ? acc[63:32] : acc[31:0];
        div_fix  = (neg_q && !raw_q) ? (32'd0 - div_word) : div_word;
        if (op_q[2])              result_c = div_fix;
        else if (op_q == OP_MUL)  result_c = prod_fix[31:0];
        else                      result_c = prod_fix[63:32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= OP_MUL;
            neg_q <= 1'b0;
            raw_q <= 1'b0;
            rd_q  <= '0;
            res_q <= '0;
        end else begin
            if (load) begin
                op_q  <= op_in;
                neg_q <= neg_in;
                raw_q <= special;
                rd_q  <= rd_addr_i;
            end
            if (state == ST_DONE) res_q <= result_c;
        end
    end

    assign rd_addr_o = rd_q;
    assign wr_data_o = (state == ST_DONE) ? result_c : res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results and latencies.
// Expected multiply latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
    localparam logic [2:0] KILL_OP = 3'b101;
`else
    localparam int MUL_LAT = 33;
    localparam logic [2:0] KILL_OP = 3'b000;
`endif
    localparam int DIV_LAT = 33;

    logic        clk, reset_n, start, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_addr;
    logic        busy_o, done_o, wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] wr_data_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    muldiv_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start),
        .kill_i     (kill),
        .funct3_i   (funct3),
        .rs1_data_i (rs1),
        .rs2_data_i (rs2),
        .rd_addr_i  (rd_addr),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .wr_en_o    (wr_en_o),
        .rd_addr_o  (rd_addr_o),
        .wr_data_o  (wr_data_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_addr = rd;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int n;
        logic [31:0] e;
        exp_q.push_back(exp);
        launch(f, a, b, rd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < 60);
        e = exp_q.pop_front();
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_data"}, wr_data_o, e);
        check({tag, "_wren"}, 32'(wr_en_o), 32'(rd != 5'd0));
        check({tag, "_rd"}, 32'(rd_addr_o), 32'(rd));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_hold"}, wr_data_o, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_wren"}, 32'(wr_en_o), 32'd0);
        check({tag, "_rdaddr"}, 32'(rd_addr_o), 32'd0);
        check({tag, "_wdata"}, wr_data_o, 32'd0);
    endtask

    initial begin
        int n;
        logic seen_done;
        logic [31:0] prev;

        reset_n = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = 3'b000; rs1 = '0; rs2 = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,          5'd7,  32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, MUL_LAT);

        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,  5'd10, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,  5'd11, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu",   3'b101, 32'd100,       32'd7,  5'd12, 32'd14,        DIV_LAT);
        run_op("remu",   3'b111, 32'd100,       32'd7,  5'd13, 32'd2,         DIV_LAT);

        run_op("divu0",  3'b101, 32'd5,         32'd0,  5'd14, 32'hFFFF_FFFF, 1);
        run_op("rem0",   3'b110, 32'd5,         32'd0,  5'd15, 32'd5,         1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1);

        // Kill while computing: busy drops next cycle, no done, result unchanged.
        prev = wr_data_o;
        launch(KILL_OP, 32'd5, 32'd6, 5'd3);
        repeat (10) @(negedge clk);
        check("kill_busy_before", 32'(busy_o), 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy_after", 32'(busy_o), 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("kill_no_done", 32'(seen_done), 32'd0);
        check("kill_wdata", wr_data_o, prev);

        // Start while busy is ignored.
        launch(3'b101, 32'd100, 32'd7, 5'd5);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd3; rd_addr = 5'd9;
        @(posedge clk);
        #1 start = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < 60);
        check("busy_start_lat", 32'(n), 32'd33);
        check("busy_start_data", wr_data_o, 32'd14);
        check("busy_start_rd", 32'(rd_addr_o), 32'd5);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("busy_start_no_second", 32'(seen_done), 32'd0);
        check("busy_start_idle", 32'(busy_o), 32'd0);

        run_op("rd0", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, MUL_LAT);

        // Reset in the middle of a divide.
        launch(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_hold");
        reset_n = 1'b1;
        @(negedge clk);
        run_op("divu_after_reset", 3'b101, 32'd9, 32'd3, 5'd6, 32'd3, DIV_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
